// File: rtl/mips_tb_pkg.sv
// Shared types and helpers for the MIPS run monitor: state encoding and width sizing.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } monitor_state_t;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_RUN     = 2'd1;
  localparam logic [1:0] STATE_HALTED  = 2'd2;
  localparam logic [1:0] STATE_TIMEOUT = 2'd3;

  // Bit width needed to index `value` items, never less than one bit.
  function automatic int width_for(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/mips_trace_buffer.sv
// Circular trace of logged results with occupancy, sticky overflow and
// registered read addressed relative to the oldest retained entry.
module mips_trace_buffer
  import mips_tb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [width_for(TRACE_DEPTH)-1:0]    rd_idx,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [width_for(TRACE_DEPTH+1)-1:0]  count,
  output logic                                 overflow
);

  localparam int PW = width_for(TRACE_DEPTH);
  localparam int CW = width_for(TRACE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(TRACE_DEPTH);

  logic [DATA_WIDTH-1:0] mem [TRACE_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_addr;
  logic                  full;
  logic                  rd_valid;

  assign full     = (count == FULL);
  // A full buffer's count truncates to 0 here, which is the correct modulo result.
  assign rd_addr  = wr_ptr - count[PW-1:0] + rd_idx;
  assign rd_valid = (CW'(rd_idx) < count);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (full) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_valid ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/mips_result_monitor.sv
// Bounded run monitor for the single-cycle MIPS: logs result changes, halts on a
// stable result, or times out after a cycle budget.
module mips_result_monitor
  import mips_tb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TRACE_DEPTH    = 16,
  parameter int STALL_LIMIT    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start_i,
  input  logic [DATA_WIDTH-1:0]                   result_i,
  input  logic [width_for(TRACE_DEPTH)-1:0]       rd_idx_i,
  output logic [DATA_WIDTH-1:0]                   rd_data_o,
  output logic [1:0]                              state_o,
  output logic                                    done_o,
  output logic                                    halted_o,
  output logic                                    timeout_o,
  output logic                                    overflow_o,
  output logic [width_for(TIMEOUT_CYCLES+1)-1:0]  cycle_count_o,
  output logic [width_for(TRACE_DEPTH+1)-1:0]     trace_count_o,
  output logic [DATA_WIDTH-1:0]                   final_result_o
);

  localparam int CYW = width_for(TIMEOUT_CYCLES + 1);
  localparam int SW  = width_for(STALL_LIMIT + 1);
  localparam logic [CYW-1:0] CYCLE_LIMIT = CYW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]  STALL_LAST  = SW'(STALL_LIMIT - 1);

  monitor_state_t        state;
  monitor_state_t        state_next;
  logic [SW-1:0]         stable_cnt;
  logic [CYW-1:0]        cycle_count;
  logic [DATA_WIDTH-1:0] final_result;
  logic                  first;
  logic                  sampling;
  logic                  changed;
  logic                  enter_run;
  logic                  hit_halt;
  logic                  hit_timeout;

  // final_result doubles as the previous sample; the first flag masks its cleared value.
  assign sampling    = (state == RUN);
  assign changed     = first || (result_i != final_result);
  assign hit_halt    = sampling && !changed && (stable_cnt == STALL_LAST);
  assign hit_timeout = sampling && ((cycle_count + CYW'(1)) == CYCLE_LIMIT);

  always_comb begin
    state_next = state;
    enter_run  = 1'b0;
    case (state)
      IDLE, HALTED, TIMEOUT: begin
        if (start_i) begin
          state_next = RUN;
          enter_run  = 1'b1;
        end
      end
      RUN: begin
        if (hit_halt) begin
          state_next = HALTED;
        end else if (hit_timeout) begin
          state_next = TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count  <= '0;
      stable_cnt   <= '0;
      first        <= 1'b0;
      final_result <= '0;
    end else if (enter_run) begin
      cycle_count  <= '0;
      stable_cnt   <= '0;
      first        <= 1'b1;
      final_result <= '0;
    end else if (sampling) begin
      cycle_count  <= cycle_count + CYW'(1);
      final_result <= result_i;
      first        <= 1'b0;
      stable_cnt   <= changed ? '0 : stable_cnt + SW'(1);
    end
  end

  mips_trace_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .clear    (enter_run),
    .wr_en    (sampling && changed),
    .wr_data  (result_i),
    .rd_idx   (rd_idx_i),
    .rd_data  (rd_data_o),
    .count    (trace_count_o),
    .overflow (overflow_o)
  );

  assign state_o        = state;
  assign done_o         = (state_o == STATE_HALTED) || (state_o == STATE_TIMEOUT);
  assign halted_o       = (state_o == STATE_HALTED);
  assign timeout_o      = (state_o == STATE_TIMEOUT);
  assign cycle_count_o  = cycle_count;
  assign final_result_o = final_result;

endmodule

// File: tb/tb_mips_result_monitor.sv
// Directed bench driving three monitor configurations in parallel, checked every
// cycle against a history-based model plus hand-computed expectations.
module tb_mips_result_monitor;

  localparam int NI = 3;
  localparam int HN = 4096;
  int p_depth [NI] = '{16, 4, 16};
  int p_stall [NI] = '{8, 8, 3};
  int p_tmo   [NI] = '{1024, 16, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] result = '0;
  logic [3:0]  rd_idx = '0;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] o_rd [NI];
  logic [31:0] o_state [NI];
  logic [31:0] o_done [NI];
  logic [31:0] o_halt [NI];
  logic [31:0] o_tmo [NI];
  logic [31:0] o_ovf [NI];
  logic [31:0] o_cyc [NI];
  logic [31:0] o_cnt [NI];
  logic [31:0] o_fin [NI];

  logic [1:0]  st0, st1, st2;
  logic        dn0, dn1, dn2, hl0, hl1, hl2, to0, to1, to2, ov0, ov1, ov2;
  logic [10:0] cy0;
  logic [4:0]  cy1;
  logic [2:0]  cy2;
  logic [4:0]  tc0, tc2;
  logic [2:0]  tc1;
  logic [31:0] rd0, rd1, rd2, fr0, fr1, fr2;

  always #5 clk = ~clk;

  mips_result_monitor u_dut0 (
    .clk(clk), .reset(reset), .start_i(start), .result_i(result), .rd_idx_i(rd_idx),
    .rd_data_o(rd0), .state_o(st0), .done_o(dn0), .halted_o(hl0), .timeout_o(to0),
    .overflow_o(ov0), .cycle_count_o(cy0), .trace_count_o(tc0), .final_result_o(fr0)
  );

  mips_result_monitor #(.TRACE_DEPTH(4), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start), .result_i(result), .rd_idx_i(rd_idx[1:0]),
    .rd_data_o(rd1), .state_o(st1), .done_o(dn1), .halted_o(hl1), .timeout_o(to1),
    .overflow_o(ov1), .cycle_count_o(cy1), .trace_count_o(tc1), .final_result_o(fr1)
  );

  mips_result_monitor #(.STALL_LIMIT(3), .TIMEOUT_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(reset), .start_i(start), .result_i(result), .rd_idx_i(rd_idx),
    .rd_data_o(rd2), .state_o(st2), .done_o(dn2), .halted_o(hl2), .timeout_o(to2),
    .overflow_o(ov2), .cycle_count_o(cy2), .trace_count_o(tc2), .final_result_o(fr2)
  );

  assign o_rd[0] = rd0;          assign o_rd[1] = rd1;          assign o_rd[2] = rd2;
  assign o_state[0] = 32'(st0);  assign o_state[1] = 32'(st1);  assign o_state[2] = 32'(st2);
  assign o_done[0] = 32'(dn0);   assign o_done[1] = 32'(dn1);   assign o_done[2] = 32'(dn2);
  assign o_halt[0] = 32'(hl0);   assign o_halt[1] = 32'(hl1);   assign o_halt[2] = 32'(hl2);
  assign o_tmo[0] = 32'(to0);    assign o_tmo[1] = 32'(to1);    assign o_tmo[2] = 32'(to2);
  assign o_ovf[0] = 32'(ov0);    assign o_ovf[1] = 32'(ov1);    assign o_ovf[2] = 32'(ov2);
  assign o_cyc[0] = 32'(cy0);    assign o_cyc[1] = 32'(cy1);    assign o_cyc[2] = 32'(cy2);
  assign o_cnt[0] = 32'(tc0);    assign o_cnt[1] = 32'(tc1);    assign o_cnt[2] = 32'(tc2);
  assign o_fin[0] = fr0;         assign o_fin[1] = fr1;         assign o_fin[2] = fr2;

  // Model keeps the full write history; retained entries are simply its newest ones.
  int          m_st [NI];
  int          m_cyc [NI];
  int          m_nwr [NI];
  int          m_rep [NI];
  bit          m_first [NI];
  logic [31:0] m_last [NI];
  logic [31:0] m_rd [NI];
  logic [31:0] m_hist [NI][HN];

  function automatic int retained(input int i);
    return (m_nwr[i] < p_depth[i]) ? m_nwr[i] : p_depth[i];
  endfunction

  task automatic check_output(input string name, input int dut,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, dut, $time, act, exp);
    end
  endtask

  task automatic model_enter_run(input int i);
    m_st[i] = 1;
    m_cyc[i] = 0;
    m_nwr[i] = 0;
    m_rep[i] = 0;
    m_first[i] = 1'b1;
    m_last[i] = '0;
  endtask

  task automatic model_step(input int i);
    int c;
    int ridx;
    c = retained(i);
    ridx = int'(rd_idx) % p_depth[i];
    m_rd[i] = (ridx < c) ? m_hist[i][(m_nwr[i] - c + ridx) % HN] : 32'd0;
    if (reset) begin
      m_st[i] = 0;
      m_cyc[i] = 0;
      m_nwr[i] = 0;
      m_rep[i] = 0;
      m_first[i] = 1'b0;
      m_last[i] = '0;
      m_rd[i] = '0;
    end else if (m_st[i] == 1) begin
      m_cyc[i]++;
      if (m_first[i] || result != m_last[i]) begin
        m_hist[i][m_nwr[i] % HN] = result;
        m_nwr[i]++;
        m_rep[i] = 0;
        m_first[i] = 1'b0;
      end else begin
        m_rep[i]++;
      end
      m_last[i] = result;
      if (m_rep[i] == p_stall[i]) m_st[i] = 2;
      else if (m_cyc[i] == p_tmo[i]) m_st[i] = 3;
    end else if (start) begin
      model_enter_run(i);
    end
  endtask

  // Single compare process: update the model on each edge, check every DUT shortly after.
  initial begin
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0; m_cyc[i] = 0; m_nwr[i] = 0; m_rep[i] = 0;
      m_first[i] = 1'b0; m_last[i] = '0; m_rd[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_step(i);
      #1;
      for (int i = 0; i < NI; i++) begin
        check_output("rd_data", i, o_rd[i], m_rd[i]);
        check_output("state", i, o_state[i], 32'(m_st[i]));
        check_output("done", i, o_done[i], 32'(m_st[i] >= 2));
        check_output("halted", i, o_halt[i], 32'(m_st[i] == 2));
        check_output("timeout", i, o_tmo[i], 32'(m_st[i] == 3));
        check_output("overflow", i, o_ovf[i], 32'(m_nwr[i] > p_depth[i]));
        check_output("cycle_count", i, o_cyc[i], 32'(m_cyc[i]));
        check_output("trace_count", i, o_cnt[i], 32'(retained(i)));
        check_output("final_result", i, o_fin[i], m_last[i]);
      end
    end
  end

  task automatic apply_stimulus(input logic st, input logic [31:0] res);
    @(negedge clk);
    start = st;
    result = res;
    @(posedge clk);
    #2;
  endtask

  task automatic read_check(input int dut, input logic [3:0] idx, input logic [31:0] exp);
    @(negedge clk);
    rd_idx = idx;
    @(posedge clk);
    #2;
    check_output("lit_read", dut, o_rd[dut], exp);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_output({tag, "_state"}, i, o_state[i], 32'd0);
      check_output({tag, "_done"}, i, o_done[i], 32'd0);
      check_output({tag, "_cycles"}, i, o_cyc[i], 32'd0);
      check_output({tag, "_count"}, i, o_cnt[i], 32'd0);
      check_output({tag, "_final"}, i, o_fin[i], 32'd0);
      check_output({tag, "_overflow"}, i, o_ovf[i], 32'd0);
      check_output({tag, "_rd"}, i, o_rd[i], 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic halt: 1,2,3 then 3 held for eight repeats.
    apply_stimulus(1'b1, 32'd0);
    apply_stimulus(1'b0, 32'd1);
    apply_stimulus(1'b0, 32'd2);
    for (int k = 0; k < 9; k++) apply_stimulus(1'b0, 32'd3);
    check_output("halt_state", 0, o_state[0], 32'd2);
    check_output("halt_cycles", 0, o_cyc[0], 32'd11);
    check_output("halt_count", 0, o_cnt[0], 32'd3);
    check_output("halt_final", 0, o_fin[0], 32'd3);
    read_check(0, 4'd0, 32'd1);
    read_check(0, 4'd1, 32'd2);
    read_check(0, 4'd2, 32'd3);
    read_check(0, 4'd3, 32'd0);

    // Overflow wrap on the four-entry instance.
    apply_stimulus(1'b1, 32'd0);
    for (int k = 10; k <= 15; k++) apply_stimulus(1'b0, 32'(k));
    for (int k = 0; k < 8; k++) apply_stimulus(1'b0, 32'd15);
    check_output("ovf_flag", 1, o_ovf[1], 32'd1);
    check_output("ovf_count", 1, o_cnt[1], 32'd4);
    check_output("ovf_state", 1, o_state[1], 32'd2);
    for (int k = 0; k < 4; k++) read_check(1, 4'(k), 32'(12 + k));

    // Restart from HALTED clears everything; start held during RUN is ignored.
    apply_stimulus(1'b1, 32'd20);
    check_output("restart_state", 1, o_state[1], 32'd1);
    check_output("restart_cycles", 1, o_cyc[1], 32'd0);
    check_output("restart_overflow", 1, o_ovf[1], 32'd0);
    check_output("restart_count", 1, o_cnt[1], 32'd0);
    apply_stimulus(1'b1, 32'd20);
    apply_stimulus(1'b1, 32'd21);
    check_output("ignore_state", 1, o_state[1], 32'd1);
    check_output("ignore_cycles", 1, o_cyc[1], 32'd2);
    check_output("ignore_count", 1, o_cnt[1], 32'd2);
    for (int k = 0; k < 12; k++) apply_stimulus(1'b0, 32'd21);

    // Timeout: a new value every cycle.
    apply_stimulus(1'b1, 32'd0);
    for (int k = 0; k < 16; k++) apply_stimulus(1'b0, 32'(100 + k));
    check_output("tmo_state", 1, o_state[1], 32'd3);
    check_output("tmo_cycles", 1, o_cyc[1], 32'd16);
    check_output("tmo_halted", 1, o_halt[1], 32'd0);
    check_output("tmo_flag", 1, o_tmo[1], 32'd1);
    for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 32'd115);

    // Halt and timeout on the same edge: halt wins.
    apply_stimulus(1'b1, 32'd0);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 32'd7);
    check_output("both_state", 2, o_state[2], 32'd2);
    check_output("both_timeout", 2, o_tmo[2], 32'd0);
    check_output("both_cycles", 2, o_cyc[2], 32'd4);
    for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 32'd7);

    // Reset between edges in the middle of a run, then a fresh run.
    apply_stimulus(1'b1, 32'd0);
    apply_stimulus(1'b0, 32'd1);
    apply_stimulus(1'b0, 32'd2);
    apply_stimulus(1'b0, 32'd3);
    #1 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, 32'd0);
    for (int k = 0; k < 9; k++) apply_stimulus(1'b0, 32'd5);
    check_output("fresh_state", 0, o_state[0], 32'd2);
    check_output("fresh_cycles", 0, o_cyc[0], 32'd9);
    check_output("fresh_count", 0, o_cnt[0], 32'd1);
    check_output("fresh_final", 0, o_fin[0], 32'd5);
    read_check(0, 4'd0, 32'd5);

    apply_stimulus(1'b0, 32'd5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_result_monitor.md
# mips_result_monitor

Parametrised run monitor for the single-cycle MIPS processor. It watches the processor's `alu_result_o` stream after `start_i` and logs every value change into a circular trace buffer. It declares the run finished when the result has been stable for a programmable number of cycles (halt), or aborts after a cycle budget (timeout). It sits beside `MIPS_Processor` in the verification environment and in on-board debug builds, and replaces free-running, unbounded simulation with a bounded, self-terminating run.

## Interface
- `DATA_WIDTH`, 32: width of the monitored result.
- `TRACE_DEPTH`, 16: trace entries; power of two, ≥2.
- `STALL_LIMIT`, 8: consecutive repeated samples that declare halt; ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum RUN samples before timeout; ≥2.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_i` in 1: start or restart a run; level sampled each edge.
- `result_i` in DATA_WIDTH: processor ALU result.
- `rd_idx_i` in clog2(TRACE_DEPTH): trace read index; 0 is the oldest retained entry.
- `rd_data_o` out DATA_WIDTH: registered trace read data.
- `state_o` out 2: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- `done_o` out 1: high in HALTED or TIMEOUT.
- `halted_o` out 1: high in HALTED.
- `timeout_o` out 1: high in TIMEOUT.
- `overflow_o` out 1: sticky; high once an entry has been overwritten in this run.
- `cycle_count_o` out clog2(TIMEOUT_CYCLES+1): RUN samples taken.
- `trace_count_o` out clog2(TRACE_DEPTH+1): valid entries; saturates at TRACE_DEPTH.
- `final_result_o` out DATA_WIDTH: last sampled result; frozen when done.

## Operation
- On reset, every output is 0, the state is IDLE, and the pointers and counters are 0. Trace contents are don't-care.
- The state machine has four states:
  - IDLE goes to RUN on `start_i`.
  - RUN goes to HALTED or TIMEOUT.
  - HALTED and TIMEOUT hold until `start_i`, which restarts the run (back to RUN).
  - `start_i` is ignored while in RUN.
- Entering RUN:
  - clears `cycle_count`, `trace_count`, the write pointer, `stable_cnt`, `overflow_o` and `final_result_o`;
  - sets an internal `first` flag.
- Each RUN edge, `result_i` is sampled and `cycle_count` is incremented. Then:
  - If `first` is set, or the sample differs from the previous sample: write it at the write pointer, increment the pointer modulo TRACE_DEPTH, clear `stable_cnt` and clear `first`.
  - Otherwise, increment `stable_cnt`.
  - In both cases, `final_result_o` takes the sample.
- Write when `trace_count == TRACE_DEPTH`: the oldest entry is overwritten, `overflow_o` is set, and `trace_count` stays at TRACE_DEPTH.
- Halt: a repeated sample with `stable_cnt == STALL_LIMIT-1` moves the state to HALTED on that edge. Halt therefore needs STALL_LIMIT+1 identical consecutive samples.
- Timeout: the edge on which `cycle_count` reaches TIMEOUT_CYCLES moves the state to TIMEOUT.
- Simultaneous halt and timeout: HALTED wins.
- Readback physical address is `(wr_ptr - trace_count + rd_idx_i) mod TRACE_DEPTH`.
  - `rd_idx_i ≥ trace_count` returns 0.
  - Readback is valid in every state.
- All arithmetic is unsigned. The pointer wraps naturally at log2(TRACE_DEPTH) bits.

## Timing
- If `start_i` is sampled high at edge N, `state_o`=RUN after N and the first sample is taken at edge N+1.
- `rd_data_o` has 1-cycle latency: it reflects the `rd_idx_i` presented before edge K after edge K.
- A write at edge K is visible to a read issued before edge K+1 (write-first ordering is not required).
- The `done_o`, `halted_o` and `timeout_o` flags and `state_o` change on the same edge.
- Reset asserted mid-RUN takes effect immediately (asynchronously). The trace is then empty and the state is IDLE.

## Structure
- Package `mips_tb_pkg` holds:
  - the `monitor_state_t` enum (IDLE, RUN, HALTED, TIMEOUT);
  - the state-encoding constants;
  - a clog2-based width helper.
- Sub-module `mips_trace_buffer`:
  - circular buffer with write pointer, occupancy counter, overflow flag and relative-index registered read;
  - parameters DATA_WIDTH and TRACE_DEPTH.
- The top level holds the state machine, the stable counter and the cycle counter.

## Test plan
- Reset mid-run: reset asserted at sample 3 of a run, between edges → all outputs 0 immediately, IDLE; a new start behaves like a fresh run.
- Basic halt (defaults): start, then result 1, 2, 3, then 3 held → changes logged; HALTED on the 8th repeat of 3. Expect cycle_count_o=11, trace_count_o=3, reads 0..2 return 1,2,3, rd_idx 3 returns 0, final_result_o=3.
- Overflow wrap (TRACE_DEPTH=4): results 10..15, each different, then held → overflow_o=1, trace_count_o=4, reads 0..3 return 12,13,14,15.
- Timeout (TIMEOUT_CYCLES=16): result increments every cycle → TIMEOUT after 16 samples, cycle_count_o=16, halted_o=0.
- Simultaneous events (STALL_LIMIT=3, TIMEOUT_CYCLES=4): constant value 7 → HALTED at sample 4, not TIMEOUT.
- Restart and ignore: `start_i` held in HALTED → RUN with all counters and overflow cleared; `start_i` during RUN → no effect.
